mem_req_queue: RTL and testbench
================================

Name: mem_req_queue

Overview:
Request buffer directly upstream of the DDR2 memory controller. Accepts 20-bit store words from the CPU-side logic through a valid/ready handshake and holds them in a small FIFO. Issues the words one at a time to the controller as a send_mem word plus a one-cycle mem_flag pulse. Waits for the controller's completion pulse before issuing the next word, so CPU bursts are never lost while a DDR2 transaction is in flight.

Parameters:
DATA_W, 20, width of each request word; matches the controller's SendMem input.
DEPTH, 8, FIFO entries; must be a power of 2 and at least 2.
TIMEOUT_CYCLES, 1024, clk_cpu cycles the block waits for mem_done before abandoning a request (used only with the optional feature).

Ports:
clk_cpu  in  1  CPU clock; all logic is on its rising edge.
rst_n  in  1  reset, asynchronous, active-low.
in_valid  in  1  upstream presents in_data.
in_data  in  DATA_W  request word.
in_ready  out  1  queue can accept a word this cycle.
send_mem  out  DATA_W  word being issued to the controller.
mem_flag  out  1  one-cycle issue strobe to the controller.
mem_done  in  1  controller completion pulse for the outstanding word.
busy  out  1  a word is outstanding (state WAIT).
level  out  $clog2(DEPTH)+1  number of stored entries, excluding the outstanding word.
timeout_err  out  1  sticky flag set when a request is abandoned (optional feature only; tied to 0 otherwise).

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk release): all outputs and state clear immediately.
  - send_mem=0, mem_flag=0, busy=0, level=0, in_ready=1, timeout_err=0.
  - Read and write pointers = 0, state=IDLE.
  - Queue contents are discarded. Reset during WAIT abandons the outstanding word with no further mem_flag.
- Storage: circular buffer with rd_ptr and wr_ptr of $clog2(DEPTH) bits each, wrapping modulo DEPTH. level is a registered count.
- in_ready = (level != DEPTH). It is combinational from the registered level only, so a full queue rejects a push even in a cycle where a pop also occurs.
- Push: when in_valid && in_ready, write mem[wr_ptr]=in_data and increment wr_ptr. If in_valid is high while in_ready is low, the word is not taken; upstream holds it.
- Pop and level update: push only gives level+1; pop only gives level-1; push and pop in the same cycle leave level unchanged.
- State machine (2 states):
  - IDLE: if level != 0, then on this edge: send_mem <= mem[rd_ptr], rd_ptr++, pop, mem_flag <= 1, busy <= 1, go to WAIT. If level == 0, stay in IDLE. mem_done in IDLE is ignored.
  - WAIT: mem_flag <= 0 on the next edge, so mem_flag is exactly one cycle wide. When mem_done=1 (sampled in any WAIT cycle, including the cycle mem_flag is high), busy <= 0 and go to IDLE. send_mem holds its value throughout WAIT and after WAIT until the next issue.
- Latency:
  - Word pushed into an empty idle queue at edge N: level=1 after N; mem_flag and send_mem valid after N+1.
  - mem_done at edge M: IDLE after M; next mem_flag after M+1 if level != 0.
  - Back-to-back issue throughput is therefore one word per (controller latency + 2) cycles.
- Ordering is strict FIFO. Issued words are never reissued.
- The push path stays active in every state, including WAIT.

Optional Feature:
Macro: MEM_REQ_QUEUE_TIMEOUT_EN.
- Defined:
  - A counter of $clog2(TIMEOUT_CYCLES)+1 bits clears on entry to WAIT and increments in each WAIT cycle without mem_done.
  - When the counter reaches TIMEOUT_CYCLES-1 without mem_done: go to IDLE, busy <= 0, timeout_err <= 1.
  - timeout_err is sticky and clears only on reset.
  - mem_done in the same cycle as the timeout wins: normal completion, no error.
- Not defined: no counter is built, WAIT is held indefinitely until mem_done, and timeout_err is tied to 0.

Test Plan:
- Single word: after reset, push 0x0ABCD in one cycle, mem_done 4 cycles after mem_flag -> mem_flag high exactly 1 cycle, one cycle after the push edge, with send_mem=0x0ABCD; busy falls on the mem_done edge; level returns to 0.
- Fill and order: with mem_done held low, push 0x00001..0x00009 on consecutive cycles -> first word issued; level reaches 8 (DEPTH); in_ready=0 while full. Pulse mem_done 8 times -> send_mem sequence 0x00002..0x00009 in order, no repeats or losses.
- Full with simultaneous pop: queue full, mem_done pulsed, in_valid=1 with 0x1FFFF -> 0x1FFFF not accepted on the pop edge; accepted the following cycle; level stays 8.
- Wrap-around: push and drain 20 words with random mem_done latency of 1..6 cycles -> pointers wrap twice; output order equals input order; mem_flag count = 20.
- Stray and early done: mem_done pulsed in IDLE with an empty queue -> no state change. mem_done in the same cycle mem_flag is high -> accepted; next word issues 2 cycles later.
- Timeout (macro defined, TIMEOUT_CYCLES=16): issue one word, never assert mem_done -> busy drops after 16 WAIT cycles; timeout_err=1 and stays 1 after a later normal transaction. Async reset asserted mid-WAIT -> mem_flag=0, busy=0, level=0 immediately.

Source files
------------

// File: rtl/mem_req_queue_if.sv
// CPU-side request and DDR2-controller-side issue signals of mem_req_queue.
// The queue takes the slave modport; the CPU logic and controller take master.
`timescale 1ns/1ps
interface mem_req_queue_if #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] send_mem;
    logic              mem_flag;
    logic              mem_done;
    logic              busy;
    logic [LVL_W-1:0]  level;
    logic              timeout_err;

    modport slave (
        input  in_valid, in_data, mem_done,
        output in_ready, send_mem, mem_flag, busy, level, timeout_err
    );
    modport master (
        output in_valid, in_data, mem_done,
        input  in_ready, send_mem, mem_flag, busy, level, timeout_err
    );
endinterface

// File: rtl/mem_req_queue.sv
// FIFO of store words in front of the DDR2 controller; one word in flight at a time.
// Optional request timeout with sticky error: define MEM_REQ_QUEUE_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_req_queue #(
    parameter int DATA_W         = 20,
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk_cpu,
    input  logic            rst_n,
    mem_req_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e                        state_q, state_d;
    logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]              level_q, level_d;
    logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;
    logic [DATA_W-1:0]             send_mem_q, send_mem_d;
    logic                          mem_flag_q, mem_flag_d;
    logic                          in_ready, push, pop;

`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // Registered level only: a full queue refuses a push even on a pop edge.
    assign in_ready = (level_q != LVL_W'(DEPTH));
    assign push     = bus.in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        mem_d      = mem_q;
        send_mem_d = send_mem_q;
        mem_flag_d = 1'b0;
        pop        = 1'b0;
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        if (push) begin
            mem_d[wr_ptr_q] = bus.in_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop        = 1'b1;
                    send_mem_d = mem_q[rd_ptr_q];
                    rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                    mem_flag_d = 1'b1;
                    state_d    = S_WAIT;
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            S_WAIT: begin
                // Completion beats a timeout landing in the same cycle.
                if (bus.mem_done) begin
                    state_d = S_IDLE;
                end
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            mem_q      <= '0;
            send_mem_q <= '0;
            mem_flag_q <= 1'b0;
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            mem_q      <= mem_d;
            send_mem_q <= send_mem_d;
            mem_flag_q <= mem_flag_d;
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.send_mem = send_mem_q;
    assign bus.mem_flag = mem_flag_q;
    assign bus.busy     = (state_q == S_WAIT);
    assign bus.level    = level_q;
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
    assign bus.timeout_err = err_q;
`else
    // Without the timeout the parameter has no hardware behind it.
    logic unused_timeout;
    assign unused_timeout  = (TIMEOUT_CYCLES != 0);
    assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_req_queue.sv
// Randomized scoreboard bench for mem_req_queue: a queue-level reference model
// predicts every cycle, and a negedge monitor checks outputs and issue order.
`timescale 1ns/1ps
module tb_mem_req_queue;
    localparam int DATA_W = 20;
    localparam int DEPTH  = 8;
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
    localparam int TO_CYC = 16;
    localparam bit TO_EN  = 1'b1;
`else
    localparam int TO_CYC = 1024;
    localparam bit TO_EN  = 1'b0;
`endif

    logic clk_cpu = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    mem_req_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
    mem_req_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk_cpu (clk_cpu),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a count of stored words, an in-flight flag and a word FIFO.
    int               m_level;
    int               m_cnt;
    bit               m_wait, m_flag, m_err, m_acc;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] hold_val;
    int               flag_cnt = 0;

    always @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            m_level = 0; m_cnt = 0; m_wait = 0; m_flag = 0; m_err = 0; m_acc = 0;
            exp_q.delete();
            hold_val = '0;
        end else begin
            bit acc, issue;
            acc   = bus.in_valid && (m_level != DEPTH);
            issue = !m_wait && (m_level != 0);
            m_acc = acc;
            if (acc) exp_q.push_back(bus.in_data);
            m_level = m_level + int'(acc) - int'(issue);
            m_flag  = issue;
            if (issue) begin
                m_wait = 1; m_cnt = 0;
            end else if (m_wait) begin
                if (bus.mem_done) m_wait = 0;
                else if (TO_EN && m_cnt == TO_CYC - 1) begin m_wait = 0; m_err = 1; end
                else m_cnt++;
            end
        end
    end

    // Monitor: pops the expected word whenever the DUT strobes mem_flag.
    always @(negedge clk_cpu) begin
        if (rst_n) begin
            chk("mem_flag", 32'(bus.mem_flag), 32'(m_flag));
            chk("busy", 32'(bus.busy), 32'(m_wait));
            chk("level", 32'(bus.level), m_level);
            chk("in_ready", 32'(bus.in_ready), 32'(m_level != DEPTH));
            chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
            if (bus.mem_flag) begin
                flag_cnt++;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL issue_order actual=%0h expected=<none> t=%0t", bus.send_mem, $time);
                end else begin
                    hold_val = exp_q.pop_front();
                end
            end
            chk("send_mem", 32'(bus.send_mem), 32'(hold_val));
        end
    end

    // Driver: upstream holds a word until accepted; controller answers after a random latency.
    logic [DATA_W-1:0] tx_q[$];
    bit                drv_valid = 0;
    logic [DATA_W-1:0] drv_data  = '0;
    int                push_pct  = 100;
    bit                auto_done = 0;
    int                lat_min = 1, lat_max = 1;
    int                done_cd = -1;

    task automatic step(input bit force_done);
        bit dn;
        @(negedge clk_cpu); #1;
        dn = force_done;
        if (drv_valid && m_acc) drv_valid = 0;
        if (!drv_valid && tx_q.size() > 0 && $urandom_range(99) < push_pct) begin
            drv_data  = tx_q.pop_front();
            drv_valid = 1;
        end
        if (auto_done) begin
            if (bus.mem_flag) done_cd = $urandom_range(lat_max, lat_min);
            if (done_cd == 0) dn = 1;
            if (done_cd >= 0) done_cd--;
        end
        bus.in_valid = drv_valid;
        bus.in_data  = drv_data;
        bus.mem_done = dn;
    endtask

    task automatic run(input int n);
        repeat (n) step(0);
    endtask

    task automatic drain(input string nm, input int max);
        int k = 0;
        while ((tx_q.size() != 0 || drv_valid || m_level != 0 || m_wait) && k < max) begin
            step(0); k++;
        end
        chk({nm, "_drain_in_time"}, 32'(k < max), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        bus.in_valid = 0; bus.in_data = '0; bus.mem_done = 0;
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_flag", 32'(bus.mem_flag), 32'd0);
        chk("rst_send_mem", 32'(bus.send_mem), 32'd0);
        chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        @(negedge clk_cpu); #2 rst_n = 1;

        // Single word, completion 4 cycles after the strobe.
        auto_done = 1; lat_min = 4; lat_max = 4; push_pct = 100;
        f0 = flag_cnt;
        tx_q.push_back(20'h0ABCD);
        drain("single", 50);
        run(2);
        chk("single_flags", flag_cnt - f0, 1);
        chk("single_send_mem", 32'(bus.send_mem), 32'h0ABCD);

        // Fill with no completions, then hold a word against the full queue.
        auto_done = 0;
        f0 = flag_cnt;
        for (int i = 1; i <= 9; i++) tx_q.push_back(DATA_W'(i));
        run(12);
        chk("fill_level", 32'(bus.level), 32'd8);
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
        tx_q.push_back(20'h1FFFF);
        run(2);
        step(1);
        run(3);
        chk("full_pop_level", 32'(bus.level), 32'd8);
        chk("full_pop_taken", 32'(drv_valid), 32'd0);
        step(1);
        auto_done = 1; lat_min = 1; lat_max = 3;
        drain("fill", 400);
        chk("fill_flags", flag_cnt - f0, 10);

        // Wrap-around: 20 random words, random gaps, completion latency 1..6.
        lat_min = 1; lat_max = 6; push_pct = 40;
        f0 = flag_cnt;
        for (int i = 0; i < 20; i++) tx_q.push_back(DATA_W'($urandom));
        drain("wrap", 2000);
        chk("wrap_flags", flag_cnt - f0, 20);

        // Stray completion in IDLE, then completion in the strobe cycle itself.
        auto_done = 0; push_pct = 100;
        step(1);
        run(2);
        chk("stray_level", 32'(bus.level), 32'd0);
        chk("stray_busy", 32'(bus.busy), 32'd0);
        auto_done = 1; lat_min = 0; lat_max = 0;
        f0 = flag_cnt;
        for (int i = 0; i < 4; i++) tx_q.push_back(DATA_W'($urandom));
        drain("early", 100);
        chk("early_flags", flag_cnt - f0, 4);

`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
        // Abandoned request, then a normal one; the error stays set.
        auto_done = 0;
        tx_q.push_back(20'h05A5A);
        run(TO_CYC + 4);
        chk("to_busy", 32'(bus.busy), 32'd0);
        chk("to_err", 32'(bus.timeout_err), 32'd1);
        auto_done = 1; lat_min = 2; lat_max = 2;
        tx_q.push_back(20'h0A5A5);
        drain("to_after", 100);
        chk("to_err_sticky", 32'(bus.timeout_err), 32'd1);
`endif

        // Asynchronous reset while the strobe is high and a word is stored.
        auto_done = 0;
        tx_q.push_back(20'h01234);
        tx_q.push_back(20'h05678);
        run(3);
        chk("pre_rst_flag", 32'(bus.mem_flag), 32'd1);
        chk("pre_rst_level", 32'(bus.level), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("async_mem_flag", 32'(bus.mem_flag), 32'd0);
        chk("async_busy", 32'(bus.busy), 32'd0);
        chk("async_level", 32'(bus.level), 32'd0);
        chk("async_in_ready", 32'(bus.in_ready), 32'd1);
        chk("async_err", 32'(bus.timeout_err), 32'd0);
        tx_q.delete(); drv_valid = 0; done_cd = -1;
        bus.in_valid = 0; bus.mem_done = 0;
        @(negedge clk_cpu); #2 rst_n = 1;
        run(4);
        chk("post_rst_send_mem", 32'(bus.send_mem), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
